// File: rtl/shift_arbiter.sv
// shift_arbiter: two-requester round-robin arbiter feeding one 4-bit shifter
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   reqN_valid/reqN_a/reqN_b        requester N operation (A = value, B = shift amount)
//   reqN_ready                      requester N accepted this cycle
//   rsp_valid/rsp_data/rsp_id/rsp_ovf, rsp_ready   result handshake
//   busy                            not idle
//   done_cnt                        completed response handshakes, wrapping
module shift_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [3:0]       req0_a,
  input  logic [3:0]       req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [3:0]       req1_a,
  input  logic [3:0]       req1_b,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic [7:0]       rsp_data,
  output logic             rsp_id,
  output logic             rsp_ovf,
  input  logic             rsp_ready,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
  state_t     r_state;
  logic       r_rr;
  logic       r_id;
  logic [3:0] r_a;
  logic [3:0] r_b;
  logic       w_idle;
  logic       w_gnt;
  logic       w_acc;
  logic [7:0] w_shift;
  assign w_idle = r_state == IDLE;
  // A lone requester wins outright; the pointer only breaks ties.
  assign w_gnt = (req0_valid & req1_valid) ? r_rr : req1_valid;
  // Handshake outputs are forced low while reset is held, even before the reset edge.
  assign w_acc = rst_n & w_idle & (req0_valid | req1_valid);
  assign req0_ready = w_acc & ~w_gnt;
  assign req1_ready = w_acc & w_gnt;
  assign busy = rst_n & ~w_idle;
  assign rsp_valid = rst_n & (r_state == RESP);
  assign w_shift = (r_b > 4'd7) ? 8'h00 : ({4'b0, r_a} << r_b[2:0]);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_rr     <= 1'b0;
      done_cnt <= '0;
      rsp_data <= 8'h00;
      rsp_id   <= 1'b0;
      rsp_ovf  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_acc) begin
          r_a     <= w_gnt ? req1_a : req0_a;
          r_b     <= w_gnt ? req1_b : req0_b;
          r_id    <= w_gnt;
          r_state <= EXEC;
        end
        EXEC: begin
          rsp_data <= w_shift;
          rsp_ovf  <= r_b > 4'd7;
          rsp_id   <= r_id;
          r_state  <= RESP;
        end
        RESP: if (rsp_ready) begin
          r_state  <= IDLE;
          r_rr     <= ~rsp_id;
          done_cnt <= done_cnt + CNT_W'(1);
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: scoreboard bench for shift_arbiter against a transaction-level model
module tb_shift_arbiter;
  localparam int CNT_W = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
  logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic req0_ready, req1_ready, rsp_valid, rsp_id, rsp_ovf, busy;
  logic [7:0] rsp_data;
  logic [CNT_W-1:0] done_cnt;
  always #5 clk = ~clk;
  shift_arbiter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_ovf(rsp_ovf),
    .rsp_ready(rsp_ready), .busy(busy), .done_cnt(done_cnt)
  );
  typedef struct {
    logic       id;
    logic [7:0] data;
    logic       ovf;
    int         t;
  } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0, cyc = 0, m_done = 0;
  logic m_rr = 1'b0;
  always @(posedge clk) cyc++;
  function automatic logic [7:0] shf(input int a, input int b);
    return (b > 7) ? 8'h00 : 8'((a * (1 << b)) % 256);
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // Model: at most one operation outstanding; its result is visible from two cycles after
  // acceptance until consumed; ties go to the requester not served last.
  always @(negedge clk) begin
    logic e_any, eg, ev;
    exp_t e;
    if (!rst_n) begin
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      q.delete();
      m_rr = 1'b0;
      m_done = 0;
    end else begin
      e_any = q.size() == 0 && (req0_valid || req1_valid);
      eg = (req0_valid && req1_valid) ? m_rr : req1_valid;
      chk("ready0", req0_ready, e_any && !eg);
      chk("ready1", req1_ready, e_any && eg);
      chk("busy", busy, q.size() != 0);
      chk("done_cnt", done_cnt, m_done % (1 << CNT_W));
      ev = q.size() != 0 && cyc >= q[0].t + 2;
      chk("rsp_valid", rsp_valid, ev);
      if (ev) begin
        chk("rsp_data", rsp_data, q[0].data);
        chk("rsp_id", rsp_id, q[0].id);
        chk("rsp_ovf", rsp_ovf, q[0].ovf);
        if (rsp_ready) begin
          m_rr = !q[0].id;
          m_done++;
          void'(q.pop_front());
        end
      end
      if (e_any) begin
        e.id = eg;
        e.data = eg ? shf(req1_a, req1_b) : shf(req0_a, req0_b);
        e.ovf = eg ? req1_b > 7 : req0_b > 7;
        e.t = cyc;
        q.push_back(e);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic op(input logic id, input logic [3:0] a, input logic [3:0] b, input logic rr);
    bit got = 0;
    req0_valid = !id; req0_a = a; req0_b = b;
    req1_valid = id;  req1_a = a; req1_b = b;
    rsp_ready = rr;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = id ? req1_ready : req0_ready;
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: id %0d never granted", id);
    end
    tick();
    req0_valid = 0; req1_valid = 0;
  endtask
  initial begin
    repeat (3) tick();
    rst_n = 1;
    tick();
    op(0, 4'hB, 4'd3, 1); repeat (4) tick();
    op(1, 4'hF, 4'd9, 1); repeat (4) tick();
    op(1, 4'hF, 4'd7, 1); repeat (4) tick();
    op(0, 4'h1, 4'd15, 1); repeat (4) tick();
    // contention with operands changing every cycle
    rsp_ready = 1; req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 30; i++) begin
      req0_a = 4'($urandom); req0_b = 4'($urandom);
      req1_a = 4'($urandom); req1_b = 4'($urandom);
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    repeat (4) tick();
    // backpressure: result parked in RESP while both requesters keep asking
    op(0, 4'h5, 4'd2, 0);
    req0_valid = 1; req1_valid = 1;
    repeat (7) tick();
    rsp_ready = 1;
    tick();
    req0_valid = 0; req1_valid = 0;
    repeat (4) tick();
    // reset while an operation is in EXEC; pointer favours requester 1 beforehand
    op(0, 4'h3, 4'd1, 1); repeat (4) tick();
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 5 && !req1_ready; i++) @(negedge clk);
    tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    repeat (6) tick();
    req0_valid = 0; req1_valid = 0;
    repeat (4) tick();
    for (int i = 0; i < 500; i++) begin
      req0_valid = 1'($urandom); req0_a = 4'($urandom); req0_b = 4'($urandom);
      req1_valid = 1'($urandom); req1_a = 4'($urandom); req1_b = 4'($urandom);
      rsp_ready = ($urandom % 4) != 0;
      rst_n = ($urandom % 100) != 0;
      tick();
    end
    rst_n = 1;
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameter CNT_W, default 8: width of the completed-operation counter.
REQ-002 Clock and reset SHALL be: one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-005 req0_valid  input  1  requester 0 has an operation pending.
REQ-006 req0_a  input  4  requester 0 operand A, the value to shift.
REQ-007 req0_b  input  4  requester 0 operand B, the shift amount.
REQ-008 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-009 req1_valid, req1_a, req1_b, req1_ready SHALL mirror REQ-005..REQ-008 for requester 1.
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_data  output  8  shifted result.
REQ-012 rsp_id  output  1  index of the requester that owns rsp_data.
REQ-013 rsp_ovf  output  1  shift amount of the result was greater than 7.
REQ-014 rsp_ready  input  1  consumer accepts the result.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done_cnt  output  CNT_W  number of completed response handshakes.

Function
REQ-017 The block SHALL contain exactly one shift unit that computes {4'b0,A} << B when B <= 7, and 8'h00 when B > 7.
REQ-018 The FSM SHALL have three states, IDLE, EXEC and RESP, encoded as 2 bits; the fourth code SHALL return to IDLE.
REQ-019 In IDLE, if one or both valid inputs are high, the block SHALL grant exactly one requester.
REQ-020 Grant selection: with one requester valid, that requester is granted; with both valid, the requester named by the round-robin pointer rr is granted.
REQ-021 reqN_ready SHALL be high only in IDLE, only for the granted requester, and SHALL be combinational from state, rr and the valid inputs.
REQ-022 On an accept edge, the block SHALL latch A, B and the requester id into internal registers and move to EXEC.
REQ-023 In EXEC, the block SHALL register the shift result into rsp_data, set rsp_ovf to (B > 7), drive rsp_id from the latched id, and move to RESP unconditionally.
REQ-024 In RESP, rsp_valid SHALL be 1, and rsp_data, rsp_id and rsp_ovf SHALL hold stable until the handshake.
REQ-025 When rsp_valid and rsp_ready are both high, the block SHALL return to IDLE, set rr to the opposite of rsp_id, and increment done_cnt.
REQ-026 done_cnt SHALL wrap modulo 2^CNT_W.
REQ-027 Latency: rsp_valid SHALL rise exactly 2 cycles after the accept edge.
REQ-028 Throughput: back-to-back operations SHALL have a minimum of 3 cycles between accept edges.
REQ-029 No new operation SHALL be accepted while in EXEC or RESP; both ready outputs SHALL stay low.
REQ-030 rsp_ready high outside RESP SHALL be ignored.
REQ-031 Operand changes on non-accept cycles SHALL NOT affect an in-flight result.
REQ-032 A requester that drops valid before being granted SHALL NOT be served.

Reset
REQ-033 While rst_n is low at a clk edge, the block SHALL set state=IDLE, rr=0, done_cnt=0, rsp_data=0, rsp_id=0, rsp_ovf=0.
REQ-034 During and after reset, rsp_valid, busy and both ready outputs SHALL be 0.
REQ-035 Reset asserted in EXEC or RESP SHALL discard the in-flight result with no response handshake.
REQ-036 The first grant after reset SHALL go to requester 0 when both requesters are valid.

Verification
REQ-037 Single op: req0 with A=4'hB, B=3 accepted -> 2 cycles later rsp_valid=1, rsp_data=8'h58, rsp_id=0, rsp_ovf=0.
REQ-038 Overflow: req1 with A=4'hF, B=9 -> rsp_data=8'h00, rsp_ovf=1, rsp_id=1; with B=7 -> rsp_data=8'h80, rsp_ovf=0.
REQ-039 Contention: both requesters continuously valid, rsp_ready=1 -> grants alternate 0,1,0,1, accept edges 3 cycles apart, done_cnt increments 1 per op.
REQ-040 Backpressure: rsp_ready held low 5 cycles in RESP -> outputs stable, both readies low; rsp_ready=1 -> return to IDLE next edge.
REQ-041 Reset mid-op: rst_n low during EXEC -> next cycle state IDLE, rsp_valid=0, done_cnt=0, rr=0.
REQ-042 Wrap: with CNT_W=2, 5 completed ops -> done_cnt=1.
